latch_bank_arbiter: RTL and testbench
=====================================

Name: latch_bank_arbiter

Overview:
- Shares one bank of edge-triggered D latch rows (DATA_W bits per row, 2**ADDR_W rows) between two writers, CPU and DSP.
- Sequences each latch row's clock so that the latch sees a clean low-to-high edge in MasterClock-sampled mode.
- Drives the bank-wide active-low latch clear.
- Sits between the Slipstream register decode and the latch bank; all timing is in MasterClock cycles.

Parameters:
ADDR_W, 4, row-select width; the bank has 2**ADDR_W rows.
DATA_W, 8, latch row data width.
HOLD_CYCLES, 2, MasterClock cycles latch_clk is held high (minimum 1).
CLEAR_CYCLES, 2, MasterClock cycles latch_rL is held low during a clear (minimum 1).

Ports:
MasterClock  in  1  the only clock; all logic updates on its rising edge.
reset  in  1  synchronous, active-high.
cpu_req  in  1  CPU write request; held until cpu_ack.
cpu_addr  in  ADDR_W  CPU target row.
cpu_data  in  DATA_W  CPU write data.
cpu_ack  out  1  one-cycle pulse when the CPU write completes.
dsp_req, dsp_addr, dsp_data, dsp_ack  same as the cpu_* ports, for the DSP.
clr_req  in  1  request to clear the whole bank; held until clr_ack.
clr_ack  out  1  one-cycle pulse when the clear completes.
latch_d  out  DATA_W  data presented to all rows.
latch_clk  out  2**ADDR_W  per-row clock, one-hot or all zero.
latch_rL  out  1  bank clear, active low.
grant  out  2  current owner: bit0 = CPU, bit1 = DSP, both 0 = none or clear.
busy  out  1  high whenever the state is not IDLE.

Behaviour:
- All outputs are registered.
- Reset values: latch_d=0, latch_clk=0, latch_rL=1, grant=0, busy=0, acks=0, state=IDLE, last_owner=DSP.
- Reset does not clear the latches themselves.
- Reset asserted mid-operation: every output takes its reset value at the next edge and any in-flight write is abandoned, with no ack. Requests still pending when reset is released are re-arbitrated from IDLE.
- States: IDLE, SETUP, STROBE, RELEASE, CLEAR.
- IDLE, arbitration priority:
  - clr_req wins; go to CLEAR.
  - Else, only one of cpu_req/dsp_req high: that requester wins.
  - Else, both high (round-robin): the requester that is not last_owner wins.
  - On a write grant, capture addr and data, set grant, and go to SETUP.
- SETUP (1 cycle): latch_d = captured data; latch_clk all 0. This guarantees the row sees clk low before the rising edge.
- STROBE (HOLD_CYCLES cycles): latch_clk[captured addr]=1, all other bits 0; latch_d held.
- RELEASE (1 cycle):
  - latch_clk all 0; latch_d held.
  - Owner's ack = 1; last_owner updated.
  - Next state is IDLE; grant clears on entry to IDLE.
- Write latency: the request is sampled in IDLE at cycle N; the first latch_clk high is at N+2; the ack is at N+2+HOLD_CYCLES. Next arbitration is at N+3+HOLD_CYCLES.
- Requester rule: deassert req on the edge that samples ack. A req still high in the following IDLE cycle is treated as a new request.
- CLEAR: latch_rL=0 for CLEAR_CYCLES cycles; latch_clk all 0; grant=0. On the last cycle clr_ack=1, then go to IDLE with latch_rL=1.
- clr_req arriving during a write stays pending and is served at the next IDLE, ahead of any write requests.
- A request that changes addr or data while it is being served has no effect; the values captured in IDLE are used.
- A row is never clocked while latch_rL=0.
- There is no write-then-clear or clear-then-write overlap.

Optional Feature:
Macro LATCH_ARB_FIXED_PRIORITY_EN.
- Defined: the CPU always beats the DSP when both request; last_owner is unused. Clear keeps top priority.
- Undefined: round-robin as described in Behaviour.

Test Plan:
- Single write: CPU writes addr=3, data=0xA5, HOLD_CYCLES=2 -> latch_clk=0x0008 for exactly 2 cycles, preceded by 1 cycle of latch_clk=0; latch_d=0xA5 from SETUP through RELEASE; cpu_ack 4 cycles after sampling; a model latch row 3 holds 0xA5.
- Contention: cpu_req and dsp_req both held continuously after reset -> grants alternate CPU, DSP, CPU, DSP; with LATCH_ARB_FIXED_PRIORITY_EN, all grants go to the CPU until cpu_req drops.
- Clear during write: clr_req raised in SETUP of a DSP write to addr=15 -> the write completes with dsp_ack; then latch_rL=0 for 2 cycles, then clr_ack; all model rows read 0.
- Clear beats write: clr_req and cpu_req both high in IDLE -> CLEAR runs first; the CPU write follows and is acked.
- Reset mid-STROBE: reset pulsed for 1 cycle -> the next edge shows latch_clk=0, busy=0, no ack; the still-held cpu_req is re-served from IDLE with full latency.
- Back-to-back: CPU holds req after ack for one extra cycle -> a second write is performed and acked; the bench verifies exactly 2 strobes.

Source files
------------

// File: rtl/latch_bank_arbiter.sv
// Two-writer arbiter and clock sequencer for a bank of edge-triggered latch rows.
// Define LATCH_ARB_FIXED_PRIORITY_EN to make the CPU always beat the DSP; default is round-robin.
module latch_bank_arbiter #(
  parameter int ADDR_W       = 4,
  parameter int DATA_W       = 8,
  parameter int HOLD_CYCLES  = 2,
  parameter int CLEAR_CYCLES = 2
) (
  input  logic                   MasterClock,
  input  logic                   reset,
  input  logic                   cpu_req,
  input  logic [ADDR_W-1:0]      cpu_addr,
  input  logic [DATA_W-1:0]      cpu_data,
  output logic                   cpu_ack,
  input  logic                   dsp_req,
  input  logic [ADDR_W-1:0]      dsp_addr,
  input  logic [DATA_W-1:0]      dsp_data,
  output logic                   dsp_ack,
  input  logic                   clr_req,
  output logic                   clr_ack,
  output logic [DATA_W-1:0]      latch_d,
  output logic [(1<<ADDR_W)-1:0] latch_clk,
  output logic                   latch_rL,
  output logic [1:0]             grant,
  output logic                   busy,
  output logic [2:0]             dbg_state_o
);

  localparam int ROWS    = 1 << ADDR_W;
  localparam int CNT_MAX = (HOLD_CYCLES > CLEAR_CYCLES) ? HOLD_CYCLES : CLEAR_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [ROWS-1:0] ONE_ROW = ROWS'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_STROBE  = 3'd2,
    S_RELEASE = 3'd3,
    S_CLEAR   = 3'd4
  } state_t;

  // Handshake: a requester raises req with stable addr/data and holds it until it
  // samples its one-cycle ack; req dropped on that edge ends the transaction.
  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                owner_dsp_q;
  logic [DATA_W-1:0]   latch_d_q;
  logic [ROWS-1:0]     latch_clk_q;
  logic                latch_rL_q;
  logic [1:0]          grant_q;
  logic                busy_q;
  logic                cpu_ack_q;
  logic                dsp_ack_q;
  logic                clr_ack_q;
`ifndef LATCH_ARB_FIXED_PRIORITY_EN
  logic                last_dsp_q;
`endif

  logic arb_cpu;
  logic arb_dsp;

  // Write arbitration; a pending clear suppresses both write grants.
  always_comb begin
    arb_cpu = 1'b0;
    arb_dsp = 1'b0;
    if (!clr_req) begin
      if (cpu_req && !dsp_req) begin
        arb_cpu = 1'b1;
      end else if (dsp_req && !cpu_req) begin
        arb_dsp = 1'b1;
      end else if (cpu_req && dsp_req) begin
`ifdef LATCH_ARB_FIXED_PRIORITY_EN
        arb_cpu = 1'b1;
`else
        arb_cpu = last_dsp_q;
        arb_dsp = !last_dsp_q;
`endif
      end
    end
  end

  always_ff @(posedge MasterClock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      owner_dsp_q <= 1'b0;
      latch_d_q   <= '0;
      latch_clk_q <= '0;
      latch_rL_q  <= 1'b1;
      grant_q     <= 2'b00;
      busy_q      <= 1'b0;
      cpu_ack_q   <= 1'b0;
      dsp_ack_q   <= 1'b0;
      clr_ack_q   <= 1'b0;
`ifndef LATCH_ARB_FIXED_PRIORITY_EN
      last_dsp_q  <= 1'b1;
`endif
    end else begin
      cpu_ack_q <= 1'b0;
      dsp_ack_q <= 1'b0;
      clr_ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          latch_clk_q <= '0;
          latch_rL_q  <= 1'b1;
          grant_q     <= 2'b00;
          busy_q      <= 1'b0;
          if (clr_req) begin
            state_q    <= S_CLEAR;
            cnt_q      <= CNT_W'(CLEAR_CYCLES - 1);
            latch_rL_q <= 1'b0;
            busy_q     <= 1'b1;
            clr_ack_q  <= (CLEAR_CYCLES == 1);
          end else if (arb_cpu || arb_dsp) begin
            state_q     <= S_SETUP;
            owner_dsp_q <= arb_dsp;
            addr_q      <= arb_dsp ? dsp_addr : cpu_addr;
            latch_d_q   <= arb_dsp ? dsp_data : cpu_data;
            grant_q     <= {arb_dsp, arb_cpu};
            busy_q      <= 1'b1;
          end
        end
        // One cycle with the row clock low guarantees a clean rising edge next.
        S_SETUP: begin
          state_q     <= S_STROBE;
          cnt_q       <= CNT_W'(HOLD_CYCLES - 1);
          latch_clk_q <= ONE_ROW << addr_q;
        end
        S_STROBE: begin
          if (cnt_q == '0) begin
            state_q     <= S_RELEASE;
            latch_clk_q <= '0;
            cpu_ack_q   <= !owner_dsp_q;
            dsp_ack_q   <= owner_dsp_q;
`ifndef LATCH_ARB_FIXED_PRIORITY_EN
            last_dsp_q  <= owner_dsp_q;
`endif
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_RELEASE: begin
          state_q <= S_IDLE;
          grant_q <= 2'b00;
          busy_q  <= 1'b0;
        end
        S_CLEAR: begin
          latch_clk_q <= '0;
          if (cnt_q == '0) begin
            state_q    <= S_IDLE;
            latch_rL_q <= 1'b1;
            busy_q     <= 1'b0;
          end else begin
            cnt_q     <= cnt_q - 1'b1;
            clr_ack_q <= (cnt_q == CNT_W'(1));
          end
        end
        default: begin
          state_q     <= S_IDLE;
          latch_clk_q <= '0;
          latch_rL_q  <= 1'b1;
          grant_q     <= 2'b00;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_ack     = cpu_ack_q;
  assign dsp_ack     = dsp_ack_q;
  assign clr_ack     = clr_ack_q;
  assign latch_d     = latch_d_q;
  assign latch_clk   = latch_clk_q;
  assign latch_rL    = latch_rL_q;
  assign grant       = grant_q;
  assign busy        = busy_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_latch_bank_arbiter.sv
// Bench for latch_bank_arbiter: fixed vector table, scripted corner sequences and
// randomized traffic checked against a transaction-schedule model and a latch-bank observer.
module tb_latch_bank_arbiter;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int HOLD   = 2;
  localparam int CLR    = 2;
  localparam int ROWS   = 16;
`ifdef LATCH_ARB_FIXED_PRIORITY_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              cpu_req, dsp_req, clr_req;
  logic [ADDR_W-1:0] cpu_addr, dsp_addr;
  logic [DATA_W-1:0] cpu_data, dsp_data;
  logic              cpu_ack, dsp_ack, clr_ack, latch_rL, busy;
  logic [DATA_W-1:0] latch_d;
  logic [ROWS-1:0]   latch_clk;
  logic [1:0]        grant;
  logic [2:0]        dbg_state;

  always #5 clk = ~clk;

  latch_bank_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .HOLD_CYCLES(HOLD), .CLEAR_CYCLES(CLR)) dut (
    .MasterClock(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_ack(cpu_ack),
    .dsp_req(dsp_req), .dsp_addr(dsp_addr), .dsp_data(dsp_data), .dsp_ack(dsp_ack),
    .clr_req(clr_req), .clr_ack(clr_ack),
    .latch_d(latch_d), .latch_clk(latch_clk), .latch_rL(latch_rL),
    .grant(grant), .busy(busy), .dbg_state_o(dbg_state)
  );

  typedef struct packed {
    logic [7:0]  d;
    logic [15:0] lclk;
    logic        rl;
    logic [1:0]  grant;
    logic        busy, cpu_ack, dsp_ack, clr_ack;
  } out_t;

  typedef struct packed {
    out_t       o;
    logic       wr;
    logic [3:0] row;
  } exp_t;

  typedef struct packed {
    logic       rst, creq;
    logic [3:0] caddr;
    logic [7:0] cdata;
    logic       dreq;
    logic [3:0] daddr;
    logic [7:0] ddata;
    logic       clr;
    out_t       exp;
  } vec_t;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   strobes = 0;
  out_t act, cur;
  logic [ROWS-1:0] prev_clk = '0;
  logic [7:0] bank [ROWS];
  logic [7:0] mem  [ROWS];

  exp_t exp_q[$];
  bit   m_idle = 1'b1;
  bit   m_last_dsp = 1'b1;
  logic [7:0] m_last_d = '0;

  function automatic out_t mk(logic [7:0] d, logic [15:0] c, logic rl, logic [1:0] g,
                              logic b, logic ca, logic da, logic cl);
    mk = {d, c, rl, g, b, ca, da, cl};
  endfunction

  function automatic vec_t mkv(logic rst, logic creq, logic [3:0] ca, logic [7:0] cd,
                               logic dreq, logic [3:0] da, logic [7:0] dd, logic clr, out_t e);
    mkv = {rst, creq, ca, cd, dreq, da, dd, clr, e};
  endfunction

  task automatic check_out(string name, out_t exp, out_t got);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d actual=%h required=%h (d,clk,rL,grant,busy,cack,dack,clrack)",
               name, cyc, got, exp);
    end
  endtask

  task automatic check_val(string name, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, got, exp);
    end
  endtask

  // Advance one clock, sample outputs and update the observed latch bank.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    act = {latch_d, latch_clk, latch_rL, grant, busy, cpu_ack, dsp_ack, clr_ack};
    for (int r = 0; r < ROWS; r++) begin
      if (latch_clk[r] && !prev_clk[r]) begin
        strobes++;
        if (latch_rL) bank[r] = latch_d;
      end
    end
    if (!latch_rL) for (int r = 0; r < ROWS; r++) bank[r] = '0;
    check_val("clk_during_clear", {31'd0, (!latch_rL && latch_clk != '0)}, 32'd0);
    prev_clk = latch_clk;
  endtask

  // Model: a granted transaction expands into its full output schedule.
  task automatic push_write(bit to_dsp, logic [3:0] a, logic [7:0] v);
    exp_t e;
    logic [1:0] g;
    g = to_dsp ? 2'b10 : 2'b01;
    e.row = a;
    e.wr = 1'b0;
    e.o = mk(v, 16'h0, 1'b1, g, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(e);
    for (int h = 0; h < HOLD; h++) begin
      e.wr = (h == 0);
      e.o = mk(v, 16'(1) << a, 1'b1, g, 1'b1, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(e);
    end
    e.wr = 1'b0;
    e.o = mk(v, 16'h0, 1'b1, g, 1'b1, !to_dsp, to_dsp, 1'b0);
    exp_q.push_back(e);
    m_last_d = v;
  endtask

  task automatic push_clear();
    exp_t e;
    e.wr = 1'b0;
    e.row = '0;
    for (int c = 0; c < CLR; c++) begin
      e.o = mk(m_last_d, 16'h0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, (c == CLR - 1));
      exp_q.push_back(e);
    end
  endtask

  task automatic mstep();
    exp_t e;
    bit to_dsp;
    if (reset) begin
      exp_q.delete();
      m_last_dsp = 1'b1;
      m_last_d = '0;
    end else if (m_idle) begin
      if (clr_req) push_clear();
      else if (cpu_req || dsp_req) begin
        if (cpu_req && dsp_req) to_dsp = FIXED ? 1'b0 : !m_last_dsp;
        else to_dsp = dsp_req;
        push_write(to_dsp, to_dsp ? dsp_addr : cpu_addr, to_dsp ? dsp_data : cpu_data);
      end
    end
    tick();
    if (exp_q.size() == 0) begin
      m_idle = 1'b1;
      e.o = mk(m_last_d, 16'h0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      e.wr = 1'b0;
      e.row = '0;
    end else begin
      m_idle = 1'b0;
      e = exp_q.pop_front();
    end
    if (e.wr) mem[e.row] = e.o.d;
    if (!e.o.rl) for (int r = 0; r < ROWS; r++) mem[r] = '0;
    if (e.o.cpu_ack) m_last_dsp = 1'b0;
    if (e.o.dsp_ack) m_last_dsp = 1'b1;
    cur = e.o;
    check_out("model", e.o, act);
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    mstep();
    reset = 1'b0;
  endtask

  // Let every requester finish, dropping each req on its ack.
  task automatic drain(string tag);
    int n;
    n = 0;
    while ((cpu_req || dsp_req || clr_req || cur.busy) && n < 40) begin
      mstep();
      n++;
      if (cur.cpu_ack) cpu_req = 1'b0;
      if (cur.dsp_ack) dsp_req = 1'b0;
      if (cur.clr_ack) clr_req = 1'b0;
    end
    check_val({tag, "_drain"}, {31'd0, (n < 40)}, 32'd1);
  endtask

  vec_t tbl [14];
  logic [1:0] got_q[$];
  logic [1:0] prev_g;
  int t_dack, t_cack, t_clr, rl_low, cnt, acks, s0;
  bit allz;

  initial begin
    reset = 1'b1; cpu_req = 0; dsp_req = 0; clr_req = 0;
    cpu_addr = '0; dsp_addr = '0; cpu_data = '0; dsp_data = '0;
    cur = '0;

    tbl[0]  = mkv(1, 0, 0, 8'h00, 0, 0, 8'h00, 0, mk(8'h00, 16'h0000, 1, 2'b00, 0, 0, 0, 0));
    tbl[1]  = mkv(0, 1, 3, 8'hA5, 0, 0, 8'h00, 0, mk(8'hA5, 16'h0000, 1, 2'b01, 1, 0, 0, 0));
    tbl[2]  = mkv(0, 1, 3, 8'hA5, 0, 0, 8'h00, 0, mk(8'hA5, 16'h0008, 1, 2'b01, 1, 0, 0, 0));
    tbl[3]  = mkv(0, 1, 3, 8'hA5, 0, 0, 8'h00, 0, mk(8'hA5, 16'h0008, 1, 2'b01, 1, 0, 0, 0));
    tbl[4]  = mkv(0, 1, 3, 8'hA5, 0, 0, 8'h00, 0, mk(8'hA5, 16'h0000, 1, 2'b01, 1, 1, 0, 0));
    tbl[5]  = mkv(0, 0, 3, 8'hA5, 0, 0, 8'h00, 0, mk(8'hA5, 16'h0000, 1, 2'b00, 0, 0, 0, 0));
    tbl[6]  = mkv(0, 0, 0, 8'h00, 0, 0, 8'h00, 1, mk(8'hA5, 16'h0000, 0, 2'b00, 1, 0, 0, 0));
    tbl[7]  = mkv(0, 0, 0, 8'h00, 0, 0, 8'h00, 1, mk(8'hA5, 16'h0000, 0, 2'b00, 1, 0, 0, 1));
    tbl[8]  = mkv(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, mk(8'hA5, 16'h0000, 1, 2'b00, 0, 0, 0, 0));
    tbl[9]  = mkv(0, 0, 0, 8'h00, 1, 15, 8'h3C, 0, mk(8'h3C, 16'h0000, 1, 2'b10, 1, 0, 0, 0));
    tbl[10] = mkv(0, 0, 0, 8'h00, 1, 15, 8'h3C, 0, mk(8'h3C, 16'h8000, 1, 2'b10, 1, 0, 0, 0));
    tbl[11] = mkv(0, 0, 0, 8'h00, 1, 15, 8'h3C, 0, mk(8'h3C, 16'h8000, 1, 2'b10, 1, 0, 0, 0));
    tbl[12] = mkv(0, 0, 0, 8'h00, 1, 15, 8'h3C, 0, mk(8'h3C, 16'h0000, 1, 2'b10, 1, 0, 1, 0));
    tbl[13] = mkv(0, 0, 0, 8'h00, 0, 15, 8'h3C, 0, mk(8'h3C, 16'h0000, 1, 2'b00, 0, 0, 0, 0));

    for (int i = 0; i < 14; i++) begin
      reset = tbl[i].rst; cpu_req = tbl[i].creq; cpu_addr = tbl[i].caddr; cpu_data = tbl[i].cdata;
      dsp_req = tbl[i].dreq; dsp_addr = tbl[i].daddr; dsp_data = tbl[i].ddata; clr_req = tbl[i].clr;
      tick();
      check_out($sformatf("vec%0d", i), tbl[i].exp, act);
      if (i == 5) check_val("row3_written", {24'd0, bank[3]}, 32'hA5);
      if (i == 8) begin
        allz = 1'b1;
        for (int r = 0; r < ROWS; r++) if (bank[r] !== 8'h00) allz = 1'b0;
        check_val("table_clear_rows", {31'd0, allz}, 32'd1);
      end
      if (i == 13) check_val("row15_written", {24'd0, bank[15]}, 32'h3C);
    end
    for (int r = 0; r < ROWS; r++) mem[r] = '0;
    mem[15] = 8'h3C;

    // Contention from reset: round-robin (or CPU-only when fixed priority).
    reset_pulse();
    cpu_req = 1; cpu_addr = 4'd1; cpu_data = 8'h11;
    dsp_req = 1; dsp_addr = 4'd2; dsp_data = 8'h22;
    got_q.delete();
    prev_g = 2'b00;
    for (int n = 0; n < 24; n++) begin
      mstep();
      if (act.grant != 2'b00 && prev_g == 2'b00) got_q.push_back(act.grant);
      prev_g = act.grant;
    end
    check_val("cont_count", {31'd0, (got_q.size() >= 4)}, 32'd1);
    for (int k = 0; k < 4 && k < got_q.size(); k++)
      check_val($sformatf("cont_grant%0d", k), {30'd0, got_q[k]},
                (FIXED || (k % 2 == 0)) ? 32'd1 : 32'd2);
    drain("cont");

    // Clear raised in SETUP of a DSP write to row 15.
    reset_pulse();
    dsp_req = 1; dsp_addr = 4'd15; dsp_data = 8'h5A;
    mstep();
    clr_req = 1;
    t_dack = -1; t_clr = -1; rl_low = 0;
    for (int n = 0; n < 20 && (dsp_req || clr_req); n++) begin
      mstep();
      if (!act.rl) rl_low++;
      if (cur.dsp_ack) begin t_dack = n; dsp_req = 0; end
      if (cur.clr_ack) begin t_clr = n; clr_req = 0; end
    end
    check_val("cdw_order", {31'd0, (t_dack >= 0 && t_clr > t_dack)}, 32'd1);
    check_val("cdw_rl_low", rl_low, CLR);
    allz = 1'b1;
    for (int r = 0; r < ROWS; r++) if (bank[r] !== 8'h00) allz = 1'b0;
    check_val("cdw_rows_zero", {31'd0, allz}, 32'd1);
    drain("cdw");

    // Clear and write together in IDLE: clear first.
    clr_req = 1; cpu_req = 1; cpu_addr = 4'd2; cpu_data = 8'h77;
    mstep();
    check_val("cbw_clear_first", {29'd0, act.rl, act.grant}, 32'd0);
    t_clr = -1; t_cack = -1;
    for (int n = 0; n < 20 && (cpu_req || clr_req); n++) begin
      mstep();
      if (cur.clr_ack) begin t_clr = n; clr_req = 0; end
      if (cur.cpu_ack) begin t_cack = n; cpu_req = 0; end
    end
    check_val("cbw_order", {31'd0, (t_clr >= 0 && t_cack > t_clr)}, 32'd1);
    check_val("cbw_row2", {24'd0, bank[2]}, 32'h77);
    drain("cbw");

    // Reset pulse in the first STROBE cycle; the held request is re-served.
    cpu_req = 1; cpu_addr = 4'd7; cpu_data = 8'h19;
    mstep();
    mstep();
    check_val("rms_strobe", {16'd0, act.lclk}, 32'h0080);
    reset = 1;
    mstep();
    reset = 0;
    check_val("rms_reset", {16'd0, act.lclk, act.busy, act.cpu_ack, 6'd0}, 32'd0);
    cnt = 0;
    for (int n = 0; n < 12 && !cur.cpu_ack; n++) begin
      mstep();
      cnt++;
    end
    check_val("rms_latency", cnt, 2 + HOLD);
    cpu_req = 0;
    drain("rms");

    // Back-to-back: req held one extra cycle after the first ack.
    cpu_req = 1; cpu_addr = 4'd9; cpu_data = 8'h42;
    s0 = strobes; acks = 0;
    for (int n = 0; n < 24 && cpu_req; n++) begin
      mstep();
      if (cur.cpu_ack) begin
        acks++;
        if (acks == 2) cpu_req = 0;
      end
    end
    drain("b2b");
    check_val("b2b_acks", acks, 2);
    check_val("b2b_strobes", strobes - s0, 2);

    // Randomized traffic, occasional resets.
    for (int n = 0; n < 2500; n++) begin
      if (reset) reset = 0;
      else if ($urandom_range(0, 299) == 0) reset = 1;
      if (cur.cpu_ack) cpu_req = ($urandom_range(0, 3) == 0);
      else if (!cpu_req && $urandom_range(0, 3) == 0) begin
        cpu_req = 1; cpu_addr = 4'($urandom_range(0, 15)); cpu_data = 8'($urandom_range(0, 255));
      end else if (cpu_req && $urandom_range(0, 7) == 0) begin
        cpu_addr = 4'($urandom_range(0, 15)); cpu_data = 8'($urandom_range(0, 255));
      end
      if (cur.dsp_ack) dsp_req = ($urandom_range(0, 3) == 0);
      else if (!dsp_req && $urandom_range(0, 3) == 0) begin
        dsp_req = 1; dsp_addr = 4'($urandom_range(0, 15)); dsp_data = 8'($urandom_range(0, 255));
      end else if (dsp_req && $urandom_range(0, 7) == 0) begin
        dsp_addr = 4'($urandom_range(0, 15)); dsp_data = 8'($urandom_range(0, 255));
      end
      if (cur.clr_ack) clr_req = 0;
      else if (!clr_req && $urandom_range(0, 60) == 0) clr_req = 1;
      mstep();
    end
    reset = 0;
    drain("rand");
    for (int r = 0; r < ROWS; r++) begin
      tests++;
      if (bank[r] !== mem[r]) begin
        fails++;
        $display("FAIL row%0d actual=%h required=%h", r, bank[r], mem[r]);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
